// File: rtl/byte_stream_packer.sv
// Packs a valid-only byte stream into LANES-byte words and queues them in a DEPTH-entry FIFO.
// Optional PACK_PARITY_EN adds a per-lane even-parity output stored with each entry.
module byte_stream_packer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       flush,
  output logic [8*LANES-1:0]         out_data,
  output logic [LANES-1:0]           out_keep,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
`ifdef PACK_PARITY_EN
  ,
  output logic [LANES-1:0]           out_parity
`endif
);

  localparam int unsigned IdxW = $clog2(LANES);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic {StIdle, StFill} state_e;

  state_e                      state_q, state_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [LANES-1:0][7:0]       asm_q, asm_d;
  logic [LANES-1:0][7:0]       word_d;
  logic [LANES-1:0]            keep_d;
  logic [IdxW:0]               fill_cnt;
  logic                        complete, close;

  logic [8*LANES-1:0]          data_mem [DEPTH];
  logic [LANES-1:0]            keep_mem [DEPTH];
  logic [PtrW-1:0]             wptr_q, rptr_q;
  logic [PtrW:0]               level_q, level_d;
  logic                        overflow_q;
  logic                        pop, push_ok;

  // Packer: the incoming byte is merged before deciding whether the word closes.
  always_comb begin
    word_d   = asm_q;
    keep_d   = '0;
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    if (in_valid) word_d[idx_q] = in_data;
    fill_cnt = {1'b0, idx_q} + {{IdxW{1'b0}}, in_valid};
    complete = in_valid && (idx_q == IdxW'(LANES - 1));
    close    = complete || (flush && ((state_q == StFill) || in_valid));
    for (int unsigned k = 0; k < LANES; k++) begin
      keep_d[k] = ((IdxW + 1)'(k) < fill_cnt);
    end
    if (close) begin
      state_d = StIdle;
      idx_d   = '0;
      asm_d   = '0;
    end else if (in_valid) begin
      state_d = StFill;
      idx_d   = idx_q + 1'b1;
      asm_d   = word_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop     = out_valid && out_ready;
  assign push_ok = close && ((level_q < (PtrW + 1)'(DEPTH)) || pop);

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      asm_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      level_q <= level_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (close && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wptr_q] <= word_d;
      keep_mem[wptr_q] <= keep_d;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? data_mem[rptr_q] : '0;
  assign out_keep  = out_valid ? keep_mem[rptr_q] : '0;
  assign overflow  = overflow_q;
  assign level     = level_q;

`ifdef PACK_PARITY_EN
  logic [LANES-1:0] par_d;
  logic [LANES-1:0] par_mem [DEPTH];

  always_comb begin
    par_d = '0;
    for (int unsigned k = 0; k < LANES; k++) par_d[k] = ^word_d[k];
  end

  always_ff @(posedge clk) begin
    if (push_ok) par_mem[wptr_q] <= par_d;
  end

  assign out_parity = out_valid ? par_mem[rptr_q] : '0;
`endif

endmodule

// File: tb/tb_byte_stream_packer.sv
// Directed self-checking bench for byte_stream_packer (LANES=4, DEPTH=4).
module tb_byte_stream_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic [2:0]  level;
`ifdef PACK_PARITY_EN
  logic [3:0]  out_parity;
`endif

  int checks = 0;
  int errors = 0;

  byte_stream_packer #(.LANES(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .level     (level)
`ifdef PACK_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    in_valid = 1'b1;
    in_data  = b;
    flush    = fl;
    cyc();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_keep", 64'(out_keep), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    rst = 1'b1;

    // Full word, immediate pop
    out_ready = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    check("t1_partial_level", 64'(level), 64'd0);
    send(8'h44, 1'b0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'h44332211);
    check("t1_keep", 64'(out_keep), 64'hF);
    check("t1_level", 64'(level), 64'd1);
    cyc();
    check("t1_pop_valid", 64'(out_valid), 64'd0);

    // Flush of a partial word, then an idle flush
    out_ready = 1'b0;
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    flush = 1'b1; cyc();
    check("t2_data", 64'(out_data), 64'h0000BBAA);
    check("t2_keep", 64'(out_keep), 64'h3);
    check("t2_level", 64'(level), 64'd1);
    cyc(); flush = 1'b0;
    check("t2_idle_flush_level", 64'(level), 64'd1);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    check("t2_drained", 64'(level), 64'd0);

    // Flush coinciding with a byte, and with natural completion
    send(8'hC1, 1'b0); send(8'hC2, 1'b1);
    check("t2b_data", 64'(out_data), 64'h0000C2C1);
    check("t2b_keep", 64'(out_keep), 64'h3);
    send(8'hC3, 1'b0); send(8'hC4, 1'b0); send(8'hC5, 1'b0); send(8'hC6, 1'b1);
    check("t2b_one_push", 64'(level), 64'd2);
    out_ready = 1'b1; cyc();
    check("t2b_head2", 64'(out_data), 64'hC6C5C4C3);
    check("t2b_keep2", 64'(out_keep), 64'hF);
    cyc(); out_ready = 1'b0;
    check("t2b_drained", 64'(level), 64'd0);

    // Saturation and overflow
    for (int i = 0; i < 20; i++) begin
      send(8'(i), 1'b0);
      if (i % 4 == 3) begin
        check("t3_level", 64'(level), (i / 4 + 1 > 4) ? 64'd4 : 64'(i / 4 + 1));
        check("t3_ovf", 64'(overflow), (i == 19) ? 64'd1 : 64'd0);
        check("t3_head", 64'(out_data), 64'h03020100);
      end
    end

    // Reset clears sticky overflow and the FIFO
    rst = 1'b0; cyc();
    check("t3_rst_ovf", 64'(overflow), 64'd0);
    check("t3_rst_level", 64'(level), 64'd0);
    rst = 1'b1;

    // Push into full FIFO while popping
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
    check("t4_full", 64'(level), 64'd4);
    send(8'h30, 1'b0); send(8'h31, 1'b0); send(8'h32, 1'b0);
    out_ready = 1'b1;
    send(8'h33, 1'b0);
    check("t4_level", 64'(level), 64'd4);
    check("t4_ovf", 64'(overflow), 64'd0);
    drain_exp[0] = 32'h27262524; drain_exp[1] = 32'h2B2A2928;
    drain_exp[2] = 32'h2F2E2D2C; drain_exp[3] = 32'h33323130;
    for (int j = 0; j < 4; j++) begin
      check("t4_drain", 64'(out_data), 64'(drain_exp[j]));
      cyc();
    end
    check("t4_empty", 64'(level), 64'd0);

    // Reset mid-word discards partial bytes
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    rst = 1'b0; #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_ovf", 64'(overflow), 64'd0);
    cyc(); rst = 1'b1;
    send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0);
    check("t5_no_stale_word", 64'(level), 64'd0);
    send(8'h08, 1'b0);
    check("t5_data", 64'(out_data), 64'h08070605);
    check("t5_keep", 64'(out_keep), 64'hF);
    cyc();
    check("t5_single_word", 64'(out_valid), 64'd0);

`ifdef PACK_PARITY_EN
    out_ready = 1'b0;
    send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h03, 1'b0); send(8'h07, 1'b0);
    check("t6_data", 64'(out_data), 64'h07030100);
    check("t6_parity", 64'(out_parity), 64'b1010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
